collision_score: RTL and testbench
==================================

Name: collision_score

Overview:
- Sits directly downstream of the level/obstacle renderer and alongside the duck sprite path.
- Consumes the 4-bit obstacle pixel stream and the 4-bit duck pixel stream on the same hc/vc raster.
- Detects per-frame pixel overlap and raises a collision event for the game FSM.
- Maintains a running BCD score plus a high score for the HUD.

Parameters:
- HC_MIN, 170, first hc column counted for overlap (inclusive)
- HC_MAX, 750, last hc column counted for overlap (inclusive)
- VC_END, 516, vc line at which the frame verdict is evaluated
- HIT_THRESH, 16, minimum overlapping CLK cycles in one frame to declare a hit (1..255)
- SCORE_DIV, 2500000, CLK cycles per score point while playing (>=1)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- state  in  4  game FSM state (RUN1=5..DUCK2=10 running; IDLE=11; CHARSEL0=12; CHARSEL1=13; FAIL1=14; FAIL2=15)
- hc  in  10  horizontal raster counter
- vc  in  10  vertical raster counter
- duck_pix  in  4  duck sprite pixel (0 = transparent)
- obstacle_pix  in  4  obstacle pixel from level (0 = transparent)
- collision  out  1  one-CLK pulse on hit
- hit_latched  out  1  high from hit until next IDLE/CHARSEL
- score  out  16  current score, 4 packed BCD digits
- high_score  out  16  best score since RESET, packed BCD

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (RESET). All state in the CLK domain.
- Reset values:
  - collision=0, hit_latched=0, score=0, high_score=0.
  - FSM=S_WAIT; overlap_cnt=0; prescaler=0.
- running = state in {5..10}. reset_req = state in {IDLE, CHARSEL0, CHARSEL1}.
- overlap (combinational):
  - duck_pix!=0 AND obstacle_pix!=0 AND HC_MIN<=hc<=HC_MAX.
- overlap_cnt, 8 bits:
  - Increments on every CLK with overlap; saturates at 255.
  - Cleared on frame start: first CLK where (hc==0 && vc==0) and the previous CLK was not.
- Frame verdict:
  - Evaluated on the first CLK where vc==VC_END and the previous CLK's vc!=VC_END.
  - Counter is cleared on the following frame start, not at the verdict.
- FSM states S_WAIT, S_PLAY, S_HIT:
  - S_WAIT -> S_PLAY when running. On that transition: score<=0, prescaler<=0.
  - S_PLAY -> S_HIT at a frame verdict with overlap_cnt>=HIT_THRESH.
    - collision=1 for exactly that CLK; hit_latched<=1.
    - If score>high_score, then high_score<=score. Packed BCD compares correctly as unsigned binary.
    - Score is frozen.
  - S_PLAY -> S_WAIT when !running with no verdict hit, e.g. the FSM forces FAIL/IDLE. high_score is updated the same way.
  - S_HIT -> S_WAIT when reset_req; hit_latched<=0 on that CLK.
  - S_HIT otherwise holds: FAIL1/FAIL2, or running again without passing IDLE.
- Scoring (S_PLAY only):
  - prescaler counts 0..SCORE_DIV-1 and wraps; score increments on the wrap.
  - BCD add with digit carry: 0009 -> 0010, 0099 -> 0100.
  - Saturates at 9999 and never wraps to 0000.
  - Prescaler holds in S_WAIT and S_HIT.
- Simultaneous events:
  - If a verdict hit and a score wrap fall on the same CLK, the hit wins; the score is not incremented.
  - If a verdict hit and !running fall on the same CLK, the hit wins (-> S_HIT).
- No collision pulse is ever generated outside S_PLAY; overlap is still counted.
- RESET mid-frame or mid-hit returns everything to the reset values immediately; high_score is lost.
- Latency:
  - overlap -> counter: 1 CLK.
  - verdict edge -> collision: registered, asserted the CLK after the verdict edge is sampled.

Test Plan:
1. RESET high then low, state=IDLE for 1000 CLK -> collision=0, hit_latched=0, score=0x0000, high_score=0x0000.
2. SCORE_DIV=4, state=RUN1, no overlap for 40 CLK -> score=0x0010 and no collision. Preload to 0x0099 and advance 4 CLK -> 0x0100. Preload to 0x9999 and advance -> stays 0x9999.
3. Frame with duck_pix=1, obstacle_pix=8 at hc=300 for 16 CLK, then vc steps to 516 -> collision single pulse, hit_latched=1, score frozen, high_score=score.
4. Same as 3 with 15 overlapping CLK -> no collision. Overlap only at hc=160 (outside window) -> no collision.
5. After hit: state=FAIL1 -> hit_latched stays 1. state=IDLE -> hit_latched=0. state=RUN1 -> score restarts at 0x0000, high_score retained. Second game with a lower score -> high_score unchanged.
6. Assert RESET during S_HIT with overlap_cnt=40 -> all outputs 0 in the same cycle; after release, state=RUN2 with no overlap -> no spurious collision.

Source files
------------

// File: rtl/collision_score.sv
// Duck/obstacle overlap detector with per-frame hit verdict, BCD running score and high score.
// The game FSM drives `state`; this block tracks its own play/hit phases from it.
module collision_score #(
    parameter int HC_MIN     = 170,
    parameter int HC_MAX     = 750,
    parameter int VC_END     = 516,
    parameter int HIT_THRESH = 16,
    parameter int SCORE_DIV  = 2500000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  state,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic [3:0]  duck_pix,
    input  logic [3:0]  obstacle_pix,
    output logic        collision,
    output logic        hit_latched,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    // state   | meaning
    // S_WAIT  | idle between games, waiting for a running game state
    // S_PLAY  | game running, score accumulating, verdicts armed
    // S_HIT   | hit taken, score frozen until IDLE/CHARSEL
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2
    } fsm_t;

    localparam int              PW       = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(SCORE_DIV - 1);
    localparam logic [9:0]      HC_LO    = 10'(HC_MIN);
    localparam logic [9:0]      HC_HI    = 10'(HC_MAX);
    localparam logic [9:0]      VC_V     = 10'(VC_END);
    localparam logic [7:0]      HIT_TH   = 8'(HIT_THRESH);

    fsm_t          fsm_q, fsm_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   score_q, score_d;
    logic [15:0]   high_q, high_d;
    logic          collision_q, collision_d;
    logic          hit_latched_q, hit_latched_d;
    logic          fs_prev_q;
    logic [9:0]    vc_q;

    logic running;
    logic reset_req;
    logic overlap;
    logic at_origin;
    logic frame_start;
    logic verdict;
    logic hit;

    // Saturating 4-digit packed-BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] x);
        logic [15:0] r;
        logic        carry;
        r     = x;
        carry = 1'b1;
        if (x == 16'h9999) begin
            return x;
        end
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign running     = (state >= 4'd5) && (state <= 4'd10);
    assign reset_req   = (state >= 4'd11) && (state <= 4'd13);
    assign overlap     = (duck_pix != 4'd0) && (obstacle_pix != 4'd0) &&
                         (hc >= HC_LO) && (hc <= HC_HI);
    assign at_origin   = (hc == 10'd0) && (vc == 10'd0);
    assign frame_start = at_origin && !fs_prev_q;
    assign verdict     = (vc == VC_V) && (vc_q != VC_V);
    assign hit         = (fsm_q == S_PLAY) && verdict && (cnt_q >= HIT_TH);

    always_comb begin
        fsm_d         = fsm_q;
        pre_d         = pre_q;
        score_d       = score_q;
        high_d        = high_q;
        collision_d   = 1'b0;
        hit_latched_d = hit_latched_q;
        cnt_d         = cnt_q;

        // Counter runs in every phase; the verdict only matters in S_PLAY.
        if (frame_start) begin
            cnt_d = 8'd0;
        end else if (overlap && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (fsm_q)
            S_WAIT: begin
                if (running) begin
                    fsm_d   = S_PLAY;
                    score_d = 16'h0000;
                    pre_d   = '0;
                end
            end
            S_PLAY: begin
                if (hit) begin
                    fsm_d         = S_HIT;
                    collision_d   = 1'b1;
                    hit_latched_d = 1'b1;
                    if (score_q > high_q) high_d = score_q;
                end else if (!running) begin
                    fsm_d = S_WAIT;
                    if (score_q > high_q) high_d = score_q;
                end else if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    score_d = bcd_inc(score_q);
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            S_HIT: begin
                if (reset_req) begin
                    fsm_d         = S_WAIT;
                    hit_latched_d = 1'b0;
                end
            end
            default: fsm_d = S_WAIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fsm_q         <= S_WAIT;
            cnt_q         <= 8'd0;
            pre_q         <= '0;
            score_q       <= 16'h0000;
            high_q        <= 16'h0000;
            collision_q   <= 1'b0;
            hit_latched_q <= 1'b0;
            fs_prev_q     <= 1'b0;
            vc_q          <= 10'd0;
        end else begin
            fsm_q         <= fsm_d;
            cnt_q         <= cnt_d;
            pre_q         <= pre_d;
            score_q       <= score_d;
            high_q        <= high_d;
            collision_q   <= collision_d;
            hit_latched_q <= hit_latched_d;
            fs_prev_q     <= at_origin;
            vc_q          <= vc;
        end
    end

    assign collision   = collision_q;
    assign hit_latched = hit_latched_q;
    assign score       = score_q;
    assign high_score  = high_q;

endmodule

// File: tb/tb_collision_score.sv
// Directed bench for collision_score with a fast score prescaler (SCORE_DIV=4).
module tb_collision_score;

    logic        CLK;
    logic        RESET;
    logic [3:0]  state;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [3:0]  duck_pix;
    logic [3:0]  obstacle_pix;
    logic        collision;
    logic        hit_latched;
    logic [15:0] score;
    logic [15:0] high_score;

    int tests;
    int fails;
    int coll_cnt;

    collision_score #(
        .HC_MIN(170), .HC_MAX(750), .VC_END(516), .HIT_THRESH(16), .SCORE_DIV(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .state(state), .hc(hc), .vc(vc),
        .duck_pix(duck_pix), .obstacle_pix(obstacle_pix),
        .collision(collision), .hit_latched(hit_latched),
        .score(score), .high_score(high_score)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial coll_cnt = 0;
    always @(negedge CLK) if (collision === 1'b1) coll_cnt++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: leave origin, frame start, n overlap clocks at column h, then verdict line.
    task automatic do_frame(input int n, input logic [9:0] h, input logic [3:0] st_verdict);
        hc = 10'd1; vc = 10'd1; duck_pix = 4'd0; obstacle_pix = 4'd0;
        tick();
        hc = 10'd0; vc = 10'd0;
        tick();
        hc = h; vc = 10'd10; duck_pix = 4'd1; obstacle_pix = 4'd8;
        repeat (n) tick();
        duck_pix = 4'd0; obstacle_pix = 4'd0; vc = 10'd516; state = st_verdict;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        RESET = 1'b1; state = 4'd11; hc = 10'd0; vc = 10'd0;
        duck_pix = 4'd0; obstacle_pix = 4'd0;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (1000) tick();
        check("t1_collision", collision, 0);
        check("t1_hit_latched", hit_latched, 0);
        check("t1_score", score, 16'h0000);
        check("t1_high", high_score, 16'h0000);

        state = 4'd5;
        tick();
        check("t2_score_start", score, 16'h0000);
        repeat (40) tick();
        check("t2_score_10", score, 16'h0010);
        repeat (356) tick();
        check("t2_score_99", score, 16'h0099);
        repeat (4) tick();
        check("t2_score_100", score, 16'h0100);
        repeat (39596) tick();
        check("t2_score_9999", score, 16'h9999);
        repeat (8) tick();
        check("t2_score_sat", score, 16'h9999);
        check("t2_high_untouched", high_score, 16'h0000);
        check("t2_no_collision", coll_cnt, 0);

        do_frame(15, 10'd300, 4'd5);
        check("t4_15_no_coll", coll_cnt, 0);
        check("t4_15_no_latch", hit_latched, 0);
        do_frame(16, 10'd160, 4'd5);
        check("t4_outside_no_coll", coll_cnt, 0);
        check("t4_outside_no_latch", hit_latched, 0);

        do_frame(16, 10'd300, 4'd5);
        check("t3_collision", collision, 1);
        check("t3_hit_latched", hit_latched, 1);
        check("t3_score", score, 16'h9999);
        check("t3_high", high_score, 16'h9999);
        tick();
        check("t3_pulse_end", collision, 0);
        check("t3_one_pulse", coll_cnt, 1);

        state = 4'd14;
        repeat (5) tick();
        check("t5_fail_holds", hit_latched, 1);
        state = 4'd11;
        tick();
        check("t5_idle_clears", hit_latched, 0);
        state = 4'd5;
        tick();
        check("t5_score_restart", score, 16'h0000);
        check("t5_high_kept", high_score, 16'h9999);
        tick();
        do_frame(16, 10'd300, 4'd5);
        check("t5_collision", collision, 1);
        check("t5_hit_beats_wrap", score, 16'h0004);
        repeat (8) tick();
        check("t5_score_frozen", score, 16'h0004);
        check("t5_high_unchanged", high_score, 16'h9999);
        check("t5_pulse_count", coll_cnt, 2);

        state = 4'd11;
        tick();
        state = 4'd6;
        tick();
        do_frame(40, 10'd300, 4'd14);
        check("t6_hit_beats_stop", collision, 1);
        check("t6_hit_latched", hit_latched, 1);
        #1;
        RESET = 1'b1;
        #1;
        check("t6_rst_collision", collision, 0);
        check("t6_rst_latched", hit_latched, 0);
        check("t6_rst_score", score, 16'h0000);
        check("t6_rst_high", high_score, 16'h0000);
        tick();
        RESET = 1'b0;
        state = 4'd6;
        tick();
        do_frame(0, 10'd300, 4'd6);
        check("t6_no_spurious", collision, 0);
        check("t6_no_latch", hit_latched, 0);
        check("t6_pulse_count", coll_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
